// File: rtl/nn_pkg.sv
// nn_pkg: shared sizes, FSM state encoding and feature word type for the Neural_net datapath
package nn_pkg;
  localparam int N_ZNACAJKI = 60;
  localparam int SIRINA = 16;
  localparam int UZORAK_W = N_ZNACAJKI * SIRINA;
  localparam int CNT_W = $clog2(N_ZNACAJKI);
  typedef enum logic [1:0] {PRAZNO, PUNO, ZASTOJ} stanje_e;
  typedef logic signed [SIRINA-1:0] znacajka_t;
endpackage

// File: rtl/ucitavac_uzorka_brojac_znacajki.sv
// brojac_znacajki: beat counter with frame-length check; ports: clk, rst_n, beat_i (accepted beat), last_i, odbaci_i (flush), cnt_o (beats in frame), gotovo_o (frame complete strobe), greska_o (length error strobe)
module brojac_znacajki
  import nn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_i,
  input  logic             last_i,
  input  logic             odbaci_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             gotovo_o,
  output logic             greska_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zadnji;
  assign zadnji = cnt_q == CNT_W'(N_ZNACAJKI - 1);
  assign gotovo_o = beat_i && zadnji && last_i;
  // last too early, or the final slot filled without last
  assign greska_o = beat_i && (last_i != zadnji);
  assign cnt_o = cnt_q;
  always_comb cnt_d = (odbaci_i || gotovo_o || greska_o) ? '0 : cnt_q + CNT_W'(beat_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ucitavac_uzorka.sv
// ucitavac_uzorka: packs 60 streamed features into a double-buffered 960-bit sample; ports: feature stream in (znacajka_data/valid/last/ready), odbaci flush, sample out (uzorak/uzorak_valid/uzorak_ack), greska_duljine error pulse, broj_primljenih debug count
module ucitavac_uzorka
  import nn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SIRINA-1:0]   znacajka_data,
  input  logic                znacajka_valid,
  input  logic                znacajka_last,
  output logic                znacajka_ready,
  input  logic                odbaci,
  output logic [UZORAK_W-1:0] uzorak,
  output logic                uzorak_valid,
  input  logic                uzorak_ack,
  output logic                greska_duljine,
  output logic [CNT_W-1:0]    broj_primljenih
);
  stanje_e             state_q;
  logic [UZORAK_W-1:0] buf_q, buf_d, uzorak_q;
  logic                greska_q, beat, gotovo, greska;
  assign znacajka_ready = (state_q != ZASTOJ) && !odbaci && rst_n;
  assign beat = znacajka_valid && znacajka_ready;
  assign uzorak = uzorak_q;
  assign uzorak_valid = state_q != PRAZNO;
  assign greska_duljine = greska_q;
  brojac_znacajki u_brojac (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat_i   (beat),
    .last_i   (znacajka_last),
    .odbaci_i (odbaci),
    .cnt_o    (broj_primljenih),
    .gotovo_o (gotovo),
    .greska_o (greska)
  );
  // buf_d includes the beat being accepted so the completing beat is copied out on the same edge
  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < N_ZNACAJKI; k++)
      if (beat && broj_primljenih == CNT_W'(k)) buf_d[(N_ZNACAJKI-1-k)*SIRINA +: SIRINA] = znacajka_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) buf_q <= '0;
    else buf_q <= buf_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= PRAZNO;
      uzorak_q <= '0;
      greska_q <= 1'b0;
    end else begin
      greska_q <= greska;
      case (state_q)
        PRAZNO:
          if (gotovo) begin
            uzorak_q <= buf_d;
            state_q  <= PUNO;
          end
        PUNO:
          if (gotovo) begin
            if (uzorak_ack) uzorak_q <= buf_d;
            state_q <= uzorak_ack ? PUNO : ZASTOJ;
          end else if (uzorak_ack) state_q <= PRAZNO;
        ZASTOJ:
          if (uzorak_ack) begin
            uzorak_q <= buf_q;
            state_q  <= PUNO;
          end
        default: state_q <= PRAZNO;
      endcase
    end
endmodule

// File: tb/tb_ucitavac_uzorka.sv
// tb_ucitavac_uzorka: directed self-checking bench for the sample loader
module tb_ucitavac_uzorka;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  znacajka_data = '0;
  logic         znacajka_valid = 1'b0;
  logic         znacajka_last = 1'b0;
  logic         znacajka_ready;
  logic         odbaci = 1'b0;
  logic [959:0] uzorak;
  logic         uzorak_valid;
  logic         uzorak_ack = 1'b0;
  logic         greska_duljine;
  logic [5:0]   broj_primljenih;
  int           errors = 0;
  int           checks = 0;
  int           err_pulses = 0;

  ucitavac_uzorka dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .znacajka_data   (znacajka_data),
    .znacajka_valid  (znacajka_valid),
    .znacajka_last   (znacajka_last),
    .znacajka_ready  (znacajka_ready),
    .odbaci          (odbaci),
    .uzorak          (uzorak),
    .uzorak_valid    (uzorak_valid),
    .uzorak_ack      (uzorak_ack),
    .greska_duljine  (greska_duljine),
    .broj_primljenih (broj_primljenih)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && greska_duljine) err_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    znacajka_data = d;
    znacajka_last = l;
    znacajka_valid = 1'b1;
    tick();
    znacajka_valid = 1'b0;
    znacajka_last = 1'b0;
  endtask

  task automatic ack_pulse();
    uzorak_ack = 1'b1;
    tick();
    uzorak_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (uzorak_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", uzorak_valid); end
    checks++; if (uzorak !== '0) begin errors++; $display("FAIL reset_uzorak got %h want 0", uzorak); end
    checks++; if (znacajka_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", znacajka_ready); end
    checks++; if (greska_duljine !== 1'b0 || broj_primljenih !== 6'd0) begin errors++; $display("FAIL reset_cnt_err got %b/%0d want 0/0", greska_duljine, broj_primljenih); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (znacajka_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", znacajka_ready); end
  endtask

  task automatic test_frame();
    err_pulses = 0;
    for (int i = 1; i <= 59; i++) beat(16'(i), 1'b0);
    checks++; if (uzorak_valid !== 1'b0 || broj_primljenih !== 6'd59) begin errors++; $display("FAIL frame_pre got v=%b n=%0d want v=0 n=59", uzorak_valid, broj_primljenih); end
    beat(16'h003C, 1'b1);
    checks++; if (uzorak_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b want 1", uzorak_valid); end
    checks++; if (uzorak[959:944] !== 16'h0001) begin errors++; $display("FAIL frame_msb got %h want 0001", uzorak[959:944]); end
    checks++; if (uzorak[15:0] !== 16'h003C) begin errors++; $display("FAIL frame_lsb got %h want 003c", uzorak[15:0]); end
    checks++; if (uzorak[495:480] !== 16'h001E) begin errors++; $display("FAIL frame_mid got %h want 001e", uzorak[495:480]); end
    checks++; if (broj_primljenih !== 6'd0 || err_pulses != 0) begin errors++; $display("FAIL frame_cnt_err got n=%0d e=%0d want 0/0", broj_primljenih, err_pulses); end
  endtask

  task automatic test_back_to_back();
    znacajka_valid = 1'b1;
    znacajka_data = 16'hBBBB;
    for (int i = 0; i < 60; i++) begin
      znacajka_last = (i == 59);
      tick();
    end
    znacajka_valid = 1'b0;
    znacajka_last = 1'b0;
    checks++; if (znacajka_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", znacajka_ready); end
    checks++; if (uzorak[959:944] !== 16'h0001 || uzorak[15:0] !== 16'h003C || uzorak_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %h..%h v=%b want 0001..003c v=1", uzorak[959:944], uzorak[15:0], uzorak_valid); end
    ack_pulse();
    checks++; if (uzorak[959:944] !== 16'hBBBB || uzorak[15:0] !== 16'hBBBB) begin errors++; $display("FAIL stall_b got %h..%h want bbbb..bbbb", uzorak[959:944], uzorak[15:0]); end
    checks++; if (uzorak_valid !== 1'b1 || znacajka_ready !== 1'b1) begin errors++; $display("FAIL stall_release got v=%b r=%b want 1/1", uzorak_valid, znacajka_ready); end
    ack_pulse();
    checks++; if (uzorak_valid !== 1'b0) begin errors++; $display("FAIL ack_empty got %b want 0", uzorak_valid); end
  endtask

  task automatic test_short_frame();
    err_pulses = 0;
    for (int i = 0; i < 10; i++) beat(16'(i), i == 9);
    checks++; if (greska_duljine !== 1'b1 || broj_primljenih !== 6'd0 || uzorak_valid !== 1'b0) begin errors++; $display("FAIL short_err got e=%b n=%0d v=%b want 1/0/0", greska_duljine, broj_primljenih, uzorak_valid); end
    tick();
    checks++; if (greska_duljine !== 1'b0) begin errors++; $display("FAIL short_pulse_len got %b want 0", greska_duljine); end
    for (int i = 0; i < 60; i++) beat(16'h1000 + 16'(i), i == 59);
    checks++; if (uzorak_valid !== 1'b1 || uzorak[959:944] !== 16'h1000 || uzorak[15:0] !== 16'h103B) begin errors++; $display("FAIL short_next got v=%b %h..%h want 1 1000..103b", uzorak_valid, uzorak[959:944], uzorak[15:0]); end
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL short_pulses got %0d want 1", err_pulses); end
    ack_pulse();
  endtask

  task automatic test_no_last();
    err_pulses = 0;
    for (int i = 0; i < 60; i++) beat(16'h4000, 1'b0);
    checks++; if (greska_duljine !== 1'b1 || uzorak_valid !== 1'b0 || broj_primljenih !== 6'd0) begin errors++; $display("FAIL nolast_err got e=%b v=%b n=%0d want 1/0/0", greska_duljine, uzorak_valid, broj_primljenih); end
    beat(16'h4001, 1'b1);
    checks++; if (greska_duljine !== 1'b1 || uzorak_valid !== 1'b0) begin errors++; $display("FAIL nolast_beat61 got e=%b v=%b want 1/0", greska_duljine, uzorak_valid); end
    tick();
    checks++; if (err_pulses != 2) begin errors++; $display("FAIL nolast_pulses got %0d want 2", err_pulses); end
  endtask

  task automatic test_odbaci();
    err_pulses = 0;
    znacajka_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      znacajka_data = 16'h2000 + 16'(i);
      tick();
    end
    odbaci = 1'b1;
    #1;
    checks++; if (znacajka_ready !== 1'b0) begin errors++; $display("FAIL odbaci_ready got %b want 0", znacajka_ready); end
    tick();
    odbaci = 1'b0;
    znacajka_valid = 1'b0;
    checks++; if (broj_primljenih !== 6'd0 || greska_duljine !== 1'b0) begin errors++; $display("FAIL odbaci_cnt got n=%0d e=%b want 0/0", broj_primljenih, greska_duljine); end
    for (int i = 0; i < 60; i++) beat(16'h3000 + 16'(i), i == 59);
    checks++; if (uzorak[959:944] !== 16'h3000 || uzorak[495:480] !== 16'h301D || uzorak[15:0] !== 16'h303B) begin errors++; $display("FAIL odbaci_frame got %h %h %h want 3000 301d 303b", uzorak[959:944], uzorak[495:480], uzorak[15:0]); end
    checks++; if (uzorak_valid !== 1'b1 || err_pulses != 0) begin errors++; $display("FAIL odbaci_valid got v=%b e=%0d want 1/0", uzorak_valid, err_pulses); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 45; i++) beat(16'h5000, 1'b0);
    checks++; if (broj_primljenih !== 6'd45) begin errors++; $display("FAIL arst_pre got %0d want 45", broj_primljenih); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (uzorak_valid !== 1'b0 || uzorak !== '0) begin errors++; $display("FAIL arst_out got v=%b msb=%h want 0/0", uzorak_valid, uzorak[959:944]); end
    checks++; if (broj_primljenih !== 6'd0 || znacajka_ready !== 1'b0) begin errors++; $display("FAIL arst_cnt got n=%0d r=%b want 0/0", broj_primljenih, znacajka_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (znacajka_ready !== 1'b1 || uzorak_valid !== 1'b0) begin errors++; $display("FAIL arst_release got r=%b v=%b want 1/0", znacajka_ready, uzorak_valid); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_short_frame();
    test_no_last();
    test_odbaci();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ucitavac_uzorka.md
Name: ucitavac_uzorka

Overview:
Upstream stage of the Neural_net datapath. It receives one sonar sample as a stream of 60 signed 16-bit features over a valid/ready handshake, packs them into the 960-bit vector that Neural_net takes on `uzorak`, and presents that vector with valid/ack. Assembly and output are double-buffered, so a partially received frame never reaches the network.

Parameters:
N_ZNACAJKI, 60, features per sample.
SIRINA, 16, bits per feature.
CNT_W, $clog2(N_ZNACAJKI), beat counter width (6 at default).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
znacajka_data  in  SIRINA  feature word, signed fixed point, passed through unmodified.
znacajka_valid  in  1  feature beat valid.
znacajka_last  in  1  marks the final feature of a frame; meaningful only with valid.
znacajka_ready  out  1  block can accept a beat.
odbaci  in  1  synchronous flush of the assembly buffer.
uzorak  out  N_ZNACAJKI*SIRINA  packed sample to Neural_net.
uzorak_valid  out  1  `uzorak` holds a complete, unconsumed sample.
uzorak_ack  in  1  consumer has taken `uzorak`; ignored while uzorak_valid=0.
greska_duljine  out  1  one-cycle pulse when a frame is discarded for a length error.
broj_primljenih  out  CNT_W  beats accepted in the current frame (debug).

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state PRAZNO, counter 0, assembly buffer 0, uzorak 0, uzorak_valid 0, greska_duljine 0. znacajka_ready is 0 while rst_n=0.
- Handshake: a beat is accepted when znacajka_valid && znacajka_ready at a rising edge. Beat k (0-based) is written to buffer bits [N*S-1-k*S -: S], so the first feature lands in the MSBs.
- znacajka_ready is combinational: (state != ZASTOJ) && !odbaci && rst_n.
- Frame complete: accepted beat with counter == N-1 and last=1. The counter then returns to 0.
- Length error, either case:
  - accepted beat with last=1 and counter < N-1;
  - accepted beat with counter == N-1 and last=0.
  - Required response: discard the assembly buffer contents logically, set counter to 0, pulse greska_duljine for the following cycle, leave state and uzorak untouched.
- odbaci=1: counter goes to 0 next cycle, no error pulse, no beat accepted that cycle (ready=0). Output register and state are unaffected.
- State machine:
  - PRAZNO (output empty, loading):
    - frame complete -> copy buffer to uzorak; uzorak_valid=1 on the next cycle; go to PUNO.
  - PUNO (output valid, loading the next frame):
    - ack, no completion -> uzorak_valid=0 next cycle; go to PRAZNO.
    - ack and completion in the same cycle -> copy buffer to uzorak; stay PUNO; valid stays 1.
    - completion, no ack -> go to ZASTOJ; uzorak unchanged.
  - ZASTOJ (second frame complete, output still held, ready=0):
    - ack -> copy buffer to uzorak; go to PUNO; valid stays 1.
- uzorak is stable whenever uzorak_valid=1 and no ack has occurred.
- Latency: last beat accepted at edge t -> uzorak_valid=1 and data visible after edge t (available in cycle t+1), when the output is free.
- Throughput: one frame per 60 cycles sustained when ack is given within 60 cycles of valid.
- Asynchronous reset mid-frame or in ZASTOJ: every stored sample is lost, and all registers return to their reset values immediately.
- Width rule: the counter never exceeds N-1; no wrap beyond N-1 is possible because completion or error resets it.

Decomposition:
- Shared package `nn_pkg`:
  - N_ZNACAJKI, SIRINA, UZORAK_W = 960;
  - state encoding PRAZNO/PUNO/ZASTOJ as a 2-bit typedef;
  - feature word typedef.
- Neural_net and its controller take UZORAK_W from the same package.
- Single natural sub-module: `brojac_znacajki`. It holds the beat counter and the last/length check, and outputs the complete and error strobes.

Test Plan:
- Reset, then stream features 16'h0001..16'h003C with last on beat 60 and ack held 0 -> uzorak_valid=1 one cycle after beat 60; uzorak[959:944]=16'h0001, uzorak[15:0]=16'h003C; greska_duljine never pulses.
- Frame A ready and not acked; stream frame B (all 16'hBBBB) -> ready=0 after B's 60th beat (ZASTOJ), uzorak stays A. Pulse ack -> uzorak=B next cycle, valid stays 1, ready returns to 1.
- 10 beats then last=1 -> greska_duljine=1 for one cycle, broj_primljenih=0, uzorak_valid unchanged. Then a full valid 60-beat frame is accepted correctly.
- 60 beats with last never asserted -> error pulse after beat 60, no valid. Beat 61 with last=1 -> treated as beat 0 of the next frame (last on index 0 -> second error pulse).
- odbaci asserted after 30 beats with valid held high -> ready=0 that cycle, counter=0 next cycle, no error; the following 60-beat frame is packed from index 0.
- rst_n driven low asynchronously mid-frame (beat 45) with a valid output held -> uzorak_valid=0, uzorak=0, counter=0 immediately, without waiting for a clk edge.
